// File: rtl/button_event_arbiter.sv
// Latches button press pulses as pending requests and serves them one per offer, round-robin, over valid/ready.
// Optional auto-repeat of a held button is built when BUTTON_EVENT_ARBITER_AUTOREPEAT_EN is defined.
module button_event_arbiter #(
  parameter int WIDTH         = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  localparam int IDW          = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] btn_level,
  input  logic [WIDTH-1:0] btn_rise,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_repeat,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] rep_flag_q, rep_flag_d;
  logic [WIDTH-1:0] grant, rep_set;
  logic [IDW-1:0]   last_id_q, sel_id, cand, evt_id_q;
  logic             sel_found, evt_valid_q, evt_repeat_q, overflow_q, overflow_d;

  // Search starts just after the last winner so every button gets its turn.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      cand = (int'(last_id_q) + k >= WIDTH) ? IDW'(int'(last_id_q) + k - WIDTH)
                                            : IDW'(int'(last_id_q) + k);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == IDLE && sel_found) grant[sel_id] = 1'b1;
  end

`ifdef BUTTON_EVENT_ARBITER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX);

  logic [TW-1:0]  timer_q;
  logic [IDW-1:0] rep_id_q, rise_id;
  logic           rep_on_q, tick;

  always_comb begin
    rise_id = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (btn_rise[i]) rise_id = IDW'(i);
    end
  end

  assign tick = rep_on_q && btn_level[rep_id_q] && (timer_q == '0);

  // A repeat landing on a bit that stays pending is dropped without overflow.
  always_comb begin
    rep_set = '0;
    if (tick) rep_set[rep_id_q] = ~(pending_q[rep_id_q] & ~grant[rep_id_q]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q  <= '0;
      rep_id_q <= '0;
      rep_on_q <= 1'b0;
    end else if (|btn_rise) begin
      timer_q  <= TW'(REPEAT_DELAY - 1);
      rep_id_q <= rise_id;
      rep_on_q <= 1'b1;
    end else if (rep_on_q) begin
      if (!btn_level[rep_id_q]) rep_on_q <= 1'b0;
      else if (timer_q == '0)   timer_q  <= TW'(REPEAT_PERIOD - 1);
      else                      timer_q  <= timer_q - 1'b1;
    end
  end
`else
  logic unused_level;
  assign unused_level = ^btn_level;
  assign rep_set      = '0;
`endif

  assign pending_d  = (pending_q & ~grant) | rep_set | btn_rise;
  assign rep_flag_d = (rep_flag_q | rep_set) & ~btn_rise;
  assign overflow_d = |(btn_rise & pending_q & ~grant);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
      last_id_q    <= IDW'(WIDTH - 1);
      pending_q    <= '0;
      rep_flag_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rep_flag_q <= rep_flag_d;
      overflow_q <= overflow_d;
      case (state_q)
        IDLE: if (sel_found) begin
          state_q      <= OFFER;
          evt_valid_q  <= 1'b1;
          evt_id_q     <= sel_id;
          evt_repeat_q <= rep_flag_q[sel_id];
          last_id_q    <= sel_id;
        end
        OFFER: if (evt_ready) begin
          state_q     <= IDLE;
          evt_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_repeat = evt_repeat_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule
